// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, write-back ports, issue port, scoreboard status
// and the committed-state tap. Signals are flat vectors, port p at [p*W +: W].
interface regfile_sb_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int IDX_W = $clog2(NREG);

  logic [NRD-1:0]        rd_en_i;
  logic [NRD*IDX_W-1:0]  rd_idx_i;
  logic [NRD*XLEN-1:0]   rd_data_o;
  logic [NRD-1:0]        rd_ready_o;
  logic [NWR-1:0]        wb_en_i;
  logic [NWR*IDX_W-1:0]  wb_idx_i;
  logic [NWR*XLEN-1:0]   wb_data_i;
  logic                  iss_valid_i;
  logic [IDX_W-1:0]      iss_idx_i;
  logic                  iss_ready_o;
  logic                  flush_i;
  logic                  sb_err_o;
  logic [NREG*XLEN-1:0]  regs_o;

  modport master (
    output rd_en_i, rd_idx_i, wb_en_i, wb_idx_i, wb_data_i,
           iss_valid_i, iss_idx_i, flush_i,
    input  rd_data_o, rd_ready_o, iss_ready_o, sb_err_o, regs_o
  );

  modport slave (
    input  rd_en_i, rd_idx_i, wb_en_i, wb_idx_i, wb_data_i,
           iss_valid_i, iss_idx_i, flush_i,
    output rd_data_o, rd_ready_o, iss_ready_o, sb_err_o, regs_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register in-flight write counter,
// so ID can hold operands back until their producing write-back arrives.

// One read port: operand select with optional write-back forwarding and readiness.
module regfile_sb_rdport #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NWR    = 2,
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic                              en,
  input  logic [IDX_W-1:0]                  idx,
  input  logic [NREG-1:0][XLEN-1:0]         regs,
  input  logic [NREG-1:0][CNT_W-1:0]        cnt,
  input  logic [NWR-1:0]                    wb_en,
  input  logic [NWR-1:0][IDX_W-1:0]         wb_idx,
  input  logic [NWR-1:0][XLEN-1:0]          wb_data,
  output logic [XLEN-1:0]                   data,
  output logic                              ready
);
  logic            hit;
  logic [XLEN-1:0] byp;

  // Highest-numbered matching write-back port wins the forward (ascending scan).
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wb_en[w] && wb_idx[w] == idx) begin
        hit = 1'b1;
        byp = wb_data[w];
      end
    end
  end

  // Disabled ports and x0 read as zero and are always ready.
  always_comb begin
    data  = '0;
    ready = 1'b1;
    if (en && idx != '0) begin
      data  = (BYPASS && hit) ? byp : regs[idx];
      ready = (cnt[idx] == '0) || (BYPASS && hit && cnt[idx] == CNT_W'(1));
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);
  localparam int IDX_W = $clog2(NREG);
  localparam int DEC_W = $clog2(NWR + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  // x0 has no storage; slot 0 is spliced in as a constant zero below.
  logic [NREG-1:1][XLEN-1:0]   regs_q;
  logic [NREG-1:1][CNT_W-1:0]  cnt_q;
  logic                        sb_err_q;

  logic [NREG-1:0][XLEN-1:0]   regs_all;
  logic [NREG-1:0][CNT_W-1:0]  cnt_all;

  logic [NWR-1:0][IDX_W-1:0]   wb_idx;
  logic [NWR-1:0][XLEN-1:0]    wb_data;
  logic [NRD-1:0][IDX_W-1:0]   rd_idx;
  logic [NRD-1:0][XLEN-1:0]    rd_data;

  logic [NREG-1:1]             wr_hit;
  logic [NREG-1:1][XLEN-1:0]   wr_dat;
  logic [NREG-1:1][DEC_W-1:0]  dec_n;
  logic [NREG-1:1][CNT_W-1:0]  cnt_d;
  logic                        uflow;
  logic                        iss_ready;
  logic                        acc;

  assign wb_idx   = bus.wb_idx_i;
  assign wb_data  = bus.wb_data_i;
  assign rd_idx   = bus.rd_idx_i;
  assign regs_all = {regs_q, {XLEN{1'b0}}};
  assign cnt_all  = {cnt_q, {CNT_W{1'b0}}};

  // Issue stalls only on a saturated counter; same-cycle write-back is
  // deliberately ignored to keep this path short.
  assign iss_ready = ~bus.flush_i & ((bus.iss_idx_i == '0) | (cnt_all[bus.iss_idx_i] != CMAX));
  assign acc       = bus.iss_valid_i & iss_ready & ~bus.flush_i;

  // Per register: write-back hit, winning data (highest port) and decrement count.
  always_comb begin
    wr_hit = '0;
    wr_dat = '0;
    dec_n  = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wb_en_i[w] && wb_idx[w] == IDX_W'(r)) begin
          wr_hit[r] = 1'b1;
          wr_dat[r] = wb_data[w];
          dec_n[r]  = dec_n[r] + DEC_W'(1);
        end
      end
    end
  end

  // Next counter value floored at zero; flag any decrement below zero.
  always_comb begin
    int  sum;
    logic inc;
    sum   = 0;
    inc   = 1'b0;
    cnt_d = cnt_q;
    uflow = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc = acc && (bus.iss_idx_i == IDX_W'(r));
      if (int'(dec_n[r]) > int'(cnt_q[r])) uflow = 1'b1;
      sum = int'(cnt_q[r]) + int'(inc) - int'(dec_n[r]);
      if (sum < 0) sum = 0;
      cnt_d[r] = CNT_W'(sum);
    end
  end

  // State update: data writes survive flush, counters do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_dat[r];
      end
      cnt_q <= bus.flush_i ? '0 : cnt_d;
      if (!bus.flush_i && uflow) sb_err_q <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .CNT_W(CNT_W), .BYPASS(BYPASS)
    ) u_rd (
      .en      (bus.rd_en_i[p]),
      .idx     (rd_idx[p]),
      .regs    (regs_all),
      .cnt     (cnt_all),
      .wb_en   (bus.wb_en_i),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .data    (rd_data[p]),
      .ready   (bus.rd_ready_o[p])
    );
  end

  assign bus.rd_data_o   = rd_data;
  assign bus.iss_ready_o = iss_ready;
  assign bus.sb_err_o    = sb_err_q;
  assign bus.regs_o      = regs_all;
endmodule
